mips_multicycle_controller: RTL

- Moore FSM controller that sequences the multicycle MIPS datapath, one instruction at a time: fetch, decode, execute, memory, writeback.
- Consumes the opcode and funct fields from the datapath.
- Drives every datapath mux select and write enable, plus the 3-bit ALU control.
- Includes a retired-instruction counter and an illegal-opcode flag for debug and verification.

---
 rtl/mips_multicycle_controller.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/mips_multicycle_controller.sv
// Multicycle MIPS controller: Moore FSM driving datapath selects and enables,
// with a retired-instruction counter and an illegal-instruction debug pulse.
module mips_multicycle_controller #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    output logic             mem_to_reg,
    output logic             reg_dest,
    output logic             i_or_d,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       pc_src,
    output logic [2:0]       alu_control,
    output logic             ir_write,
    output logic             mem_write,
    output logic             pc_write,
    output logic             branch,
    output logic             reg_write,
    output logic [3:0]       state,
    output logic             illegal_op,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [3:0] FETCH  = 4'd0;
    localparam logic [3:0] DECODE = 4'd1;
    localparam logic [3:0] MEMADR = 4'd2;
    localparam logic [3:0] MEMRD  = 4'd3;
    localparam logic [3:0] MEMWB  = 4'd4;
    localparam logic [3:0] MEMWR  = 4'd5;
    localparam logic [3:0] EXEC   = 4'd6;
    localparam logic [3:0] ALUWB  = 4'd7;
    localparam logic [3:0] BEQ    = 4'd8;
    localparam logic [3:0] ADDIEX = 4'd9;
    localparam logic [3:0] ADDIWB = 4'd10;
    localparam logic [3:0] JUMP   = 4'd11;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    logic [3:0] state_q, state_d;
    logic       funct_ok;
    logic [2:0] funct_alu;
    logic       opcode_ok;
    logic       retire;
    logic       ir_write_raw, mem_write_raw, pc_write_raw, branch_raw, reg_write_raw;

    // R-type funct decode to ALU operation.
    always_comb begin
        funct_ok  = 1'b1;
        funct_alu = 3'b010;
        case (funct)
            6'b100000: funct_alu = 3'b010;
            6'b100010: funct_alu = 3'b110;
            6'b100100: funct_alu = 3'b000;
            6'b100101: funct_alu = 3'b001;
            6'b101010: funct_alu = 3'b111;
            default:   funct_ok  = 1'b0;
        endcase
    end

    // Opcode legality check used by DECODE.
    always_comb begin
        case (opcode)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: opcode_ok = 1'b1;
            default:                                       opcode_ok = 1'b0;
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:  state_d = DECODE;
            DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXEC;
                    OP_BEQ:       state_d = BEQ;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JUMP;
                    default:      state_d = FETCH;
                endcase
            end
            // IR holds the instruction, so opcode is still valid here.
            MEMADR: state_d = (opcode == OP_SW) ? MEMWR : MEMRD;
            MEMRD:  state_d = MEMWB;
            EXEC:   state_d = funct_ok ? ALUWB : FETCH;
            ADDIEX: state_d = ADDIWB;
            default: state_d = FETCH;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= FETCH;
        else          state_q <= state_d;
    end

    assign retire = (state_q == MEMWB) || (state_q == MEMWR) || (state_q == ALUWB) ||
                    (state_q == BEQ)   || (state_q == ADDIWB) || (state_q == JUMP);

    // Retired-instruction counter, bumped on the edge leaving a final state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)    instr_count <= '0;
        else if (retire) instr_count <= instr_count + CNT_W'(1);
    end

    // Moore output decode; unlisted outputs default to 0.
    always_comb begin
        mem_to_reg    = 1'b0;
        reg_dest      = 1'b0;
        i_or_d        = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        pc_src        = 2'b00;
        alu_control   = 3'b000;
        ir_write_raw  = 1'b0;
        mem_write_raw = 1'b0;
        pc_write_raw  = 1'b0;
        branch_raw    = 1'b0;
        reg_write_raw = 1'b0;
        case (state_q)
            FETCH: begin
                alu_src_b    = 2'b01;
                alu_control  = 3'b010;
                ir_write_raw = 1'b1;
                pc_write_raw = 1'b1;
            end
            DECODE: begin
                alu_src_b   = 2'b11;
                alu_control = 3'b010;
            end
            MEMADR, ADDIEX: begin
                alu_src_a   = 1'b1;
                alu_src_b   = 2'b10;
                alu_control = 3'b010;
            end
            MEMRD: i_or_d = 1'b1;
            MEMWB: begin
                mem_to_reg    = 1'b1;
                reg_write_raw = 1'b1;
            end
            MEMWR: begin
                i_or_d        = 1'b1;
                mem_write_raw = 1'b1;
            end
            EXEC: begin
                alu_src_a   = 1'b1;
                alu_control = funct_alu;
            end
            ALUWB: begin
                reg_dest      = 1'b1;
                reg_write_raw = 1'b1;
            end
            BEQ: begin
                alu_src_a   = 1'b1;
                alu_control = 3'b110;
                pc_src      = 2'b01;
                branch_raw  = 1'b1;
            end
            ADDIWB: reg_write_raw = 1'b1;
            JUMP: begin
                pc_src       = 2'b10;
                pc_write_raw = 1'b1;
            end
            default: ;
        endcase
    end

    // Enables drop asynchronously with reset so an aborted instruction writes nothing.
    assign ir_write  = ir_write_raw & reset_n;
    assign mem_write = mem_write_raw & reset_n;
    assign pc_write  = pc_write_raw & reset_n;
    assign branch    = branch_raw & reset_n;
    assign reg_write = reg_write_raw & reset_n;

    assign illegal_op = (state_q == DECODE) &&
                        (!opcode_ok || ((opcode == OP_RTYPE) && !funct_ok));
    assign state      = state_q;

endmodule
